// File: rtl/rf_recovery_seq_if.sv
// Bundle of the sequencer's links to the error detector, fetch stage,
// checkpoint bank read port and register-file write arbiter.
interface rf_recovery_seq_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
);
    logic                  error_i;
    logic                  fetch_block_o;
    logic                  rd_req_o;
    logic [ADDR_WIDTH-1:0] rd_addr_o;
    logic [DATA_WIDTH-1:0] rd_data_i;
    logic                  wr_req_o;
    logic                  wr_gnt_i;
    logic [ADDR_WIDTH-1:0] wr_addr_o;
    logic [DATA_WIDTH-1:0] wr_data_o;
    logic                  done_o;
    logic [CNT_WIDTH-1:0]  rec_count_o;

    modport master (
        input  error_i, rd_data_i, wr_gnt_i,
        output fetch_block_o, rd_req_o, rd_addr_o, wr_req_o,
        output wr_addr_o, wr_data_o, done_o, rec_count_o
    );

    modport slave (
        output error_i, rd_data_i, wr_gnt_i,
        input  fetch_block_o, rd_req_o, rd_addr_o, wr_req_o,
        input  wr_addr_o, wr_data_o, done_o, rec_count_o
    );
endinterface

// File: rtl/rf_recovery_seq.sv
// Register-file recovery sequencer: on an error, stalls fetch and copies every
// architectural register from the checkpoint bank back into the register file.
module rf_recovery_seq #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int SKIP_R0    = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               rst_i,
    rf_recovery_seq_if.master  bus
);

    localparam int NUM_REG = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] START = (SKIP_R0 != 0) ? ADDR_WIDTH'(1) : '0;
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NUM_REG - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WRITE,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_WIDTH-1:0]  rec_cnt;
    logic                  fetch_block;
    logic                  rd_req;
    logic                  wr_req;
    logic                  done;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Strobes are registered alongside the state they belong to, so each one
    // is set on the transition into its state and cleared by default otherwise.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            addr        <= START;
            data_q      <= '0;
            rec_cnt     <= '0;
            fetch_block <= 1'b0;
            rd_req      <= 1'b0;
            wr_req      <= 1'b0;
            done        <= 1'b0;
        end else begin
            rd_req <= 1'b0;
            wr_req <= 1'b0;
            done   <= 1'b0;
            if (state == LATCH) begin
                data_q <= bus.rd_data_i;
            end
            // An error in any state (re)starts the walk; a grant in this same
            // cycle has already been taken by the arbiter.
            if (bus.error_i) begin
                state       <= READ;
                addr        <= START;
                rec_cnt     <= sat_inc(rec_cnt);
                fetch_block <= 1'b1;
                rd_req      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    READ: begin
                        state <= LATCH;
                    end
                    LATCH: begin
                        state  <= WRITE;
                        wr_req <= 1'b1;
                    end
                    WRITE: begin
                        if (bus.wr_gnt_i) begin
                            if (addr == LAST) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                addr   <= addr + 1'b1;
                                state  <= READ;
                                rd_req <= 1'b1;
                            end
                        end else begin
                            wr_req <= 1'b1;
                        end
                    end
                    DONE: begin
                        state       <= IDLE;
                        addr        <= START;
                        fetch_block <= 1'b0;
                    end
                    default: begin
                        state       <= IDLE;
                        addr        <= START;
                        fetch_block <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.fetch_block_o = fetch_block;
    assign bus.rd_req_o      = rd_req;
    assign bus.rd_addr_o     = addr;
    assign bus.wr_req_o      = wr_req;
    assign bus.wr_addr_o     = addr;
    assign bus.wr_data_o     = data_q;
    assign bus.done_o        = done;
    assign bus.rec_count_o   = rec_cnt;

endmodule

// File: tb/tb_rf_recovery_seq.sv
// Bench for rf_recovery_seq: one instance skipping r0, one walking from r0,
// both driven by the same error/grant stimulus and checked against a walk model.
`timescale 1ns/1ps
module tb_rf_recovery_seq;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int CW   = 8;
    localparam int NR   = 1 << AW;
    localparam int CMAX = (1 << CW) - 1;

    localparam int P_IDLE = 0;
    localparam int P_RD   = 1;
    localparam int P_LAT  = 2;
    localparam int P_WR   = 3;
    localparam int P_DONE = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err = 1'b0;
    logic gnt = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rf_recovery_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus0 ();
    rf_recovery_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus1 ();

    rf_recovery_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SKIP_R0(1), .CNT_WIDTH(CW)) u0 (
        .clk(clk), .rst_i(rst), .bus(bus0));
    rf_recovery_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SKIP_R0(0), .CNT_WIDTH(CW)) u1 (
        .clk(clk), .rst_i(rst), .bus(bus1));

    // Checkpoint bank: answers one cycle after a read strobe, noise otherwise.
    logic [DW-1:0] bank [NR];
    logic [DW-1:0] rdd0, rdd1;
    always @(posedge clk) begin
        rdd0 <= bus0.rd_req_o ? bank[bus0.rd_addr_o] : DW'($urandom);
        rdd1 <= bus1.rd_req_o ? bank[bus1.rd_addr_o] : DW'($urandom);
    end

    assign bus0.error_i   = err;
    assign bus0.wr_gnt_i  = gnt;
    assign bus0.rd_data_i = rdd0;
    assign bus1.error_i   = err;
    assign bus1.wr_gnt_i  = gnt;
    assign bus1.rd_data_i = rdd1;

    logic          o_fb [2], o_rr [2], o_wr [2], o_dn [2];
    logic [AW-1:0] o_ra [2], o_wa [2];
    logic [DW-1:0] o_wd [2];
    logic [CW-1:0] o_rc [2];
    assign o_fb[0] = bus0.fetch_block_o;  assign o_fb[1] = bus1.fetch_block_o;
    assign o_rr[0] = bus0.rd_req_o;       assign o_rr[1] = bus1.rd_req_o;
    assign o_wr[0] = bus0.wr_req_o;       assign o_wr[1] = bus1.wr_req_o;
    assign o_dn[0] = bus0.done_o;         assign o_dn[1] = bus1.done_o;
    assign o_ra[0] = bus0.rd_addr_o;      assign o_ra[1] = bus1.rd_addr_o;
    assign o_wa[0] = bus0.wr_addr_o;      assign o_wa[1] = bus1.wr_addr_o;
    assign o_wd[0] = bus0.wr_data_o;      assign o_wd[1] = bus1.wr_data_o;
    assign o_rc[0] = bus0.rec_count_o;    assign o_rc[1] = bus1.rec_count_o;

    function automatic int start_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Walk model: which micro-step of the copy each instance is on, which
    // register it is copying, and how many recoveries have been started.
    int ph [2];
    int ma [2];
    int mc [2];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                ph[i] <= P_IDLE;
                ma[i] <= start_of(i);
                mc[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (err) begin
                    ph[i] <= P_RD;
                    ma[i] <= start_of(i);
                    mc[i] <= (mc[i] < CMAX) ? mc[i] + 1 : CMAX;
                end else begin
                    case (ph[i])
                        P_RD:  ph[i] <= P_LAT;
                        P_LAT: ph[i] <= P_WR;
                        P_WR: begin
                            if (gnt) begin
                                if (ma[i] == NR - 1) ph[i] <= P_DONE;
                                else begin
                                    ph[i] <= P_RD;
                                    ma[i] <= ma[i] + 1;
                                end
                            end
                        end
                        P_DONE: begin
                            ph[i] <= P_IDLE;
                            ma[i] <= start_of(i);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Per-cycle compare against the model, plus a write scoreboard: writes taken
    // since the last (re)start must be consecutive from START with bank data.
    int wn [2];
    initial begin
        wn[0] = 0;
        wn[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d.fetch_block", i), o_fb[i], ph[i] != P_IDLE);
                chk($sformatf("u%0d.rd_req", i), o_rr[i], ph[i] == P_RD);
                chk($sformatf("u%0d.rd_addr", i), o_ra[i], ma[i]);
                chk($sformatf("u%0d.wr_req", i), o_wr[i], ph[i] == P_WR);
                chk($sformatf("u%0d.wr_addr", i), o_wa[i], ma[i]);
                chk($sformatf("u%0d.done", i), o_dn[i], ph[i] == P_DONE);
                chk($sformatf("u%0d.rec_count", i), o_rc[i], mc[i]);
                if (ph[i] == P_WR)
                    chk($sformatf("u%0d.wr_data", i), o_wd[i], bank[ma[i]]);
                if (rst) begin
                    wn[i] = 0;
                end else begin
                    if (o_dn[i])
                        chk($sformatf("u%0d.walk_len", i), wn[i], NR - start_of(i));
                    if (o_wr[i] && gnt) begin
                        chk($sformatf("u%0d.write_order", i), o_wa[i], start_of(i) + wn[i]);
                        wn[i]++;
                    end
                    if (err) wn[i] = 0;
                end
            end
        end
    end

    typedef struct packed {
        logic          fb, rr, wr, dn;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd;
        logic [CW-1:0] rc;
    } snap_t;

    snap_t tr0 [400];
    snap_t tr1 [400];
    int    d_done0, d_done1, m_done0;

    function automatic snap_t snap(input int i);
        snap_t s;
        s.fb = o_fb[i]; s.rr = o_rr[i]; s.wr = o_wr[i]; s.dn = o_dn[i];
        s.ra = o_ra[i]; s.wa = o_wa[i]; s.wd = o_wd[i]; s.rc = o_rc[i];
        return s;
    endfunction

    // Error pulse in cycle 0, then cycles 1..ncyc with optional grant stall
    // window and a second error at err_c (with or without a grant).
    task automatic directed(input int stall_lo, input int stall_hi, input int err_c,
                            input bit err_gnt, input int ncyc);
        d_done0 = -1; d_done1 = -1; m_done0 = -1;
        @(posedge clk); #2;
        err = 1'b1; gnt = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #2;
            err = (c == err_c);
            gnt = !((c >= stall_lo && c <= stall_hi) || (c == err_c && !err_gnt));
            #4;
            tr0[c] = snap(0);
            tr1[c] = snap(1);
            if (tr0[c].dn && d_done0 < 0) d_done0 = c;
            if (tr1[c].dn && d_done1 < 0) d_done1 = c;
            if (ph[0] == P_DONE && m_done0 < 0) m_done0 = c;
        end
    endtask

    task automatic wait_idle(input int maxc);
        int c;
        c = 0;
        while ((o_fb[0] || o_fb[1]) && c < maxc) begin
            @(posedge clk); #6;
            c++;
        end
        chk("idle_timeout", o_fb[0] || o_fb[1], 1'b0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst = 1'b1; err = 1'b0; gnt = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        #4;
    endtask

    initial begin
        int ok, rc0, ndone, fb_low;
        for (int a = 0; a < NR; a++) bank[a] = $urandom;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Quiet after reset
        repeat (10) @(posedge clk);
        #6;
        chk("idle_fetch_block", o_fb[0], 1'b0);
        chk("idle_rd_req", o_rr[0], 1'b0);
        chk("idle_wr_req", o_wr[0], 1'b0);
        chk("idle_done", o_dn[0], 1'b0);
        chk("idle_rec_count", o_rc[0], 0);
        chk("idle_wr_data", o_wd[0], 0);
        chk("idle_rd_addr_u0", o_ra[0], 1);
        chk("idle_rd_addr_u1", o_ra[1], 0);

        // Uninterrupted walk, grant always high
        directed(0, -1, -1, 1'b0, 110);
        chk("walk_done_u0", d_done0, 94);
        chk("walk_done_u1", d_done1, 97);
        chk("model_done_u0", m_done0, 94);
        ok = 0;
        for (int c = 1; c <= 94; c++) if (tr0[c].fb) ok++;
        chk("walk_fetch_high", ok, 94);
        chk("walk_fetch_drop", tr0[95].fb, 1'b0);
        ok = 0;
        for (int k = 1; k <= 31; k++)
            if (tr0[3*k-2].rr && tr0[3*k-2].ra == AW'(k) && tr0[3*k].wr &&
                tr0[3*k].wa == AW'(k) && tr0[3*k].wd == bank[k]) ok++;
        chk("walk_schedule_u0", ok, 31);
        chk("walk_rec_count", tr0[95].rc, 1);
        chk("walk_first_addr_u1", tr1[1].ra, 0);
        chk("walk_last_write_u1", tr1[96].wa, 31);
        wait_idle(50);

        // Grant withheld five cycles during the write of r7
        directed(21, 25, -1, 1'b0, 120);
        ok = 0;
        for (int c = 21; c <= 26; c++)
            if (tr0[c].wr && tr0[c].wa == 7 && tr0[c].wd == bank[7]) ok++;
        chk("stall_hold_r7", ok, 6);
        chk("stall_next_addr", tr0[27].ra, 8);
        chk("stall_done_u0", d_done0, 99);
        chk("stall_done_u1", d_done1, 102);
        wait_idle(50);

        // Error during the write of r12 with no grant
        rc0 = o_rc[0];
        directed(0, -1, 36, 1'b0, 140);
        chk("err_nogrant_in_write", tr0[36].wr && tr0[36].wa == 12, 1'b1);
        chk("err_nogrant_restart", tr0[37].rr && tr0[37].ra == 1, 1'b1);
        chk("err_nogrant_rec_count", tr0[37].rc, rc0 + 2);
        ok = 0;
        for (int c = 1; c <= 130; c++) if (tr0[c].fb) ok++;
        chk("err_nogrant_fetch", ok, 130);
        chk("err_nogrant_done", d_done0, 130);
        chk("err_nogrant_done_u1", d_done1, 133);
        wait_idle(50);

        // Error coincident with the grant of r12
        directed(0, -1, 36, 1'b1, 140);
        chk("err_grant_write", tr0[36].wr && tr0[36].wa == 12 && tr0[36].wd == bank[12], 1'b1);
        chk("err_grant_restart", tr0[37].rr && tr0[37].ra == 1, 1'b1);
        chk("err_grant_done", d_done0, 130);
        wait_idle(50);

        // Asynchronous reset in the middle of LATCH
        @(posedge clk); #2;
        err = 1'b1; gnt = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #2;
            err = 1'b0;
        end
        #1;
        chk("pre_rst_busy", o_fb[0] && !o_rr[0] && !o_wr[0], 1'b1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("async_rst_u%0d_fb", i), o_fb[i], 1'b0);
            chk($sformatf("async_rst_u%0d_rr", i), o_rr[i], 1'b0);
            chk($sformatf("async_rst_u%0d_wr", i), o_wr[i], 1'b0);
            chk($sformatf("async_rst_u%0d_rc", i), o_rc[i], 0);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        ok = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #6;
            if (o_wr[0] || o_wr[1] || o_fb[0] || o_fb[1]) ok++;
        end
        chk("post_rst_quiet", ok, 0);

        // Error held high: counter saturates, fetch stays blocked, no completion
        @(posedge clk); #2;
        err = 1'b1;
        ndone = 0; fb_low = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #2;
            gnt = 1'($urandom_range(0, 1));
            #4;
            if (o_dn[0] || o_dn[1]) ndone++;
            if (!o_fb[0] || !o_fb[1]) fb_low++;
        end
        chk("held_err_rc_u0", o_rc[0], CMAX);
        chk("held_err_rc_u1", o_rc[1], CMAX);
        chk("held_err_no_done", ndone, 0);
        chk("held_err_fetch", fb_low, 0);
        @(posedge clk); #2;
        err = 1'b0; gnt = 1'b1;
        #4;
        wait_idle(200);
        chk("held_err_rc_after", o_rc[0], CMAX);

        // Randomized errors, grants and occasional resets
        pulse_reset();
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #2;
            rst = 1'b0;
            err = ($urandom_range(0, 249) == 0);
            gnt = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1999) == 0) rst = 1'b1;
            #4;
        end
        @(posedge clk); #2;
        rst = 1'b0; err = 1'b0; gnt = 1'b1;
        #4;
        wait_idle(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_recovery_seq.md
Name: rf_recovery_seq

Overview:
- Register-file recovery sequencer for the fault-tolerant core.
- When an error is flagged, it blocks instruction fetch and walks every architectural register address.
- For each address it reads the golden copy from the checkpoint bank, then writes it into the faulty core's register file through a shared, arbitrated write port.
- It sits between the error detector, the fetch stage, the checkpoint bank read port and the register-file write arbiter.

Parameters:
- ADDR_WIDTH, 5: register address width; NUM_REG = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: register data width.
- SKIP_R0, 1: 1 = start the walk at address 1 (r0 is hardwired zero); 0 = start at 0.
- CNT_WIDTH, 8: width of the recovery event counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- error_i  in  1  error flag, sampled every cycle.
- fetch_block_o  out  1  stall request to the fetch stage.
- rd_req_o  out  1  checkpoint bank read strobe.
- rd_addr_o  out  ADDR_WIDTH  checkpoint bank read address.
- rd_data_i  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_req_o.
- wr_req_o  out  1  write request to the register-file arbiter.
- wr_gnt_i  in  1  arbiter grant; the write is taken in any cycle with wr_req_o && wr_gnt_i.
- wr_addr_o  out  ADDR_WIDTH  register-file write address.
- wr_data_o  out  DATA_WIDTH  register-file write data.
- done_o  out  1  one-cycle pulse when a recovery completes.
- rec_count_o  out  CNT_WIDTH  number of recoveries started; saturates at all-ones.

Behaviour:
- Clock is clk. Reset rst_i is asynchronous and active-high.
- Reset values:
  - state = IDLE; addr = START, where START = SKIP_R0 ? 1 : 0.
  - Data register = 0; rec_count_o = 0.
  - All strobes (fetch_block_o, rd_req_o, wr_req_o, done_o) = 0.
- Reset mid-recovery aborts immediately. No write is issued after reset asserts.
- FSM states: IDLE, READ, LATCH, WRITE, DONE.
- IDLE:
  - error_i=1 -> READ with addr=START; rec_count_o increments (saturating).
  - Otherwise stay in IDLE.
- READ:
  - rd_req_o=1, rd_addr_o=addr.
  - Next state is always LATCH.
- LATCH:
  - Capture rd_data_i into the data register.
  - Next state is WRITE.
- WRITE:
  - wr_req_o=1, wr_addr_o=addr, wr_data_o=data register; all held stable until granted.
  - On grant with addr == NUM_REG-1 -> DONE.
  - On grant otherwise -> addr+1, then READ.
  - No grant -> stay in WRITE.
- DONE:
  - done_o=1 for exactly this one cycle.
  - Next state is IDLE; addr reloads START.
- fetch_block_o = (state != IDLE). It is registered through the state, so it rises the cycle after error_i is first sampled in IDLE.
- Address arithmetic:
  - addr is ADDR_WIDTH wide.
  - The last address is NUM_REG-1; termination is by compare, never by overflow wrap.
- Error while in READ, LATCH, WRITE or DONE restarts the walk:
  - Next state = READ, addr = START; rec_count_o increments.
  - Error in WRITE in the same cycle as a grant: the write is taken, then the walk restarts.
  - Error in DONE: done_o still pulses this cycle; fetch_block_o stays high continuously.
- error_i held high continuously keeps restarting every cycle. This is the required behaviour: fetch stays blocked and no recovery completes.
- Strobe values outside their state:
  - rd_req_o, wr_req_o and done_o are 0 in all other states.
  - rd_addr_o and wr_addr_o always show addr.
- Timing with no stall: 3 cycles per register, plus 1 DONE cycle.

Test Plan:
- Reset, error_i=0 for 10 cycles -> all strobes 0, rec_count_o=0, state IDLE.
- SKIP_R0=1, wr_gnt_i tied 1, error_i pulse at cycle 0:
  - fetch_block_o=1 on cycles 1..94.
  - rd_req_o at cycles 3k-2 with rd_addr_o=k; wr_req_o at cycles 3k with wr_addr_o=k and wr_data_o equal to the bank model data, for k=1..31.
  - done_o=1 at cycle 94; rec_count_o=1.
- wr_gnt_i low for 5 cycles during the write of addr 7 -> wr_req_o, wr_addr_o=7 and wr_data_o are held stable; completion shifts by 5 cycles; no address is skipped.
- error_i pulse while in WRITE of addr 12 without grant -> no write to 12; next rd_addr_o=1; rec_count_o=2; fetch_block_o never drops.
- error_i coincident with the grant of addr 12 -> the addr 12 write is observed, then the restart at addr 1.
- Assert rst_i asynchronously mid-LATCH -> outputs drop to 0 before the next edge; no write issued. SKIP_R0=0 run -> the walk covers addr 0..31 (32 writes).
